// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite response codes and watchdog FSM state types
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE  = 2'b00,
        W_RESP  = 2'b01,
        W_ERR   = 2'b10,
        W_DRAIN = 2'b11
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_RESP  = 2'b01,
        R_ERR   = 2'b10,
        R_DRAIN = 2'b11
    } rd_state_t;

    // Response code the guard itself returns when the slave stays silent
    function automatic logic [1:0] timeout_resp(input logic err_en);
        return err_en ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axil_resp_timer.sv
// rtl/axil_resp_timer.sv - saturating wait counter flagging the last allowed response cycle
module axil_resp_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic aclk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over count; the count parks at TIMEOUT instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High from the cycle the count reaches TIMEOUT-1 onward
    assign expired_o = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/axil_timeout_guard.sv
// rtl/axil_timeout_guard.sv - AXI-Lite watchdog answering for a slave that misses its B/R deadline
module axil_timeout_guard
    import axil_pkg::*;
#(
    parameter int   ADDR_W      = 32,
    parameter int   DATA_W      = 32,
    parameter int   TIMEOUT     = 256,
    parameter logic ERR_RESP_EN = 1'b0,
    localparam int  STRB_W      = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] s_axil_awaddr_i,
    input  logic [2:0]        s_axil_awprot_i,
    input  logic              s_axil_awvalid_i,
    output logic              s_axil_awready_o,
    input  logic [DATA_W-1:0] s_axil_wdata_i,
    input  logic [STRB_W-1:0] s_axil_wstrb_i,
    input  logic              s_axil_wvalid_i,
    output logic              s_axil_wready_o,
    output logic [1:0]        s_axil_bresp_o,
    output logic              s_axil_bvalid_o,
    input  logic              s_axil_bready_i,
    input  logic [ADDR_W-1:0] s_axil_araddr_i,
    input  logic [2:0]        s_axil_arprot_i,
    input  logic              s_axil_arvalid_i,
    output logic              s_axil_arready_o,
    output logic [DATA_W-1:0] s_axil_rdata_o,
    output logic [1:0]        s_axil_rresp_o,
    output logic              s_axil_rvalid_o,
    input  logic              s_axil_rready_i,
    output logic [ADDR_W-1:0] m_axil_awaddr_o,
    output logic [2:0]        m_axil_awprot_o,
    output logic              m_axil_awvalid_o,
    input  logic              m_axil_awready_i,
    output logic [DATA_W-1:0] m_axil_wdata_o,
    output logic [STRB_W-1:0] m_axil_wstrb_o,
    output logic              m_axil_wvalid_o,
    input  logic              m_axil_wready_i,
    input  logic [1:0]        m_axil_bresp_i,
    input  logic              m_axil_bvalid_i,
    output logic              m_axil_bready_o,
    output logic [ADDR_W-1:0] m_axil_araddr_o,
    output logic [2:0]        m_axil_arprot_o,
    output logic              m_axil_arvalid_o,
    input  logic              m_axil_arready_i,
    input  logic [DATA_W-1:0] m_axil_rdata_i,
    input  logic [1:0]        m_axil_rresp_i,
    input  logic              m_axil_rvalid_i,
    output logic              m_axil_rready_o,
    output logic              error_o,
    output logic [1:0]        err_src_o
);

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;
    logic      run_q;
    logic      error_q, error_d;
    logic [1:0] err_src_q, err_src_d;
    logic      wr_tmr_clr, wr_tmr_en, wr_expired;
    logic      rd_tmr_clr, rd_tmr_en, rd_expired;
    logic      wr_evt, rd_evt;
    logic      aw_hs, w_hs;

    // Request payloads always travel unchanged; only the handshakes are gated
    assign m_axil_awaddr_o = s_axil_awaddr_i;
    assign m_axil_awprot_o = s_axil_awprot_i;
    assign m_axil_wdata_o  = s_axil_wdata_i;
    assign m_axil_wstrb_o  = s_axil_wstrb_i;
    assign m_axil_araddr_o = s_axil_araddr_i;
    assign m_axil_arprot_o = s_axil_arprot_i;
    assign s_axil_rdata_o  = (rd_state_q == R_ERR) ? '0 : m_axil_rdata_i;

    axil_resp_timer #(.TIMEOUT(TIMEOUT)) u_wr_timer (
        .aclk      (aclk),
        .rstn      (rstn),
        .clr_i     (wr_tmr_clr),
        .en_i      (wr_tmr_en),
        .expired_o (wr_expired)
    );

    axil_resp_timer #(.TIMEOUT(TIMEOUT)) u_rd_timer (
        .aclk      (aclk),
        .rstn      (rstn),
        .clr_i     (rd_tmr_clr),
        .en_i      (rd_tmr_en),
        .expired_o (rd_expired)
    );

    // State, flags and error pulse registers; run_q keeps request handshakes closed while in reset
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            run_q      <= 1'b0;
            error_q    <= 1'b0;
            err_src_q  <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            run_q      <= 1'b1;
            error_q    <= error_d;
            err_src_q  <= err_src_d;
        end
    end

    // Write channel: pass AW/W, then forward B or answer it ourselves after the deadline
    always_comb begin
        wr_state_d       = wr_state_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        m_axil_awvalid_o = 1'b0;
        s_axil_awready_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        s_axil_wready_o  = 1'b0;
        s_axil_bvalid_o  = 1'b0;
        s_axil_bresp_o   = m_axil_bresp_i;
        m_axil_bready_o  = 1'b0;
        wr_tmr_clr       = 1'b0;
        wr_tmr_en        = 1'b0;
        wr_evt           = 1'b0;
        aw_hs            = 1'b0;
        w_hs             = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                wr_tmr_clr       = 1'b1;
                m_axil_awvalid_o = run_q & ~aw_done_q & s_axil_awvalid_i;
                s_axil_awready_o = run_q & ~aw_done_q & m_axil_awready_i;
                m_axil_wvalid_o  = run_q & ~w_done_q & s_axil_wvalid_i;
                s_axil_wready_o  = run_q & ~w_done_q & m_axil_wready_i;
                aw_hs            = m_axil_awvalid_o & m_axil_awready_i;
                w_hs             = m_axil_wvalid_o & m_axil_wready_i;
                aw_done_d        = aw_done_q | aw_hs;
                w_done_d         = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                wr_tmr_en       = 1'b1;
                s_axil_bvalid_o = m_axil_bvalid_i;
                m_axil_bready_o = s_axil_bready_i;
                if (m_axil_bvalid_i && s_axil_bready_i) begin
                    wr_state_d = W_IDLE;
                    wr_evt     = (m_axil_bresp_i != OKAY);
                end else if (wr_expired && !m_axil_bvalid_i) begin
                    wr_state_d = W_ERR;
                    wr_evt     = 1'b1;
                end
            end
            W_ERR: begin
                s_axil_bvalid_o = 1'b1;
                s_axil_bresp_o  = timeout_resp(ERR_RESP_EN);
                if (s_axil_bready_i) begin
                    wr_state_d = W_DRAIN;
                end
            end
            W_DRAIN: begin
                m_axil_bready_o = 1'b1;
                if (m_axil_bvalid_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read channel: same deadline scheme, independent of the write side
    always_comb begin
        rd_state_d       = rd_state_q;
        m_axil_arvalid_o = 1'b0;
        s_axil_arready_o = 1'b0;
        s_axil_rvalid_o  = 1'b0;
        s_axil_rresp_o   = m_axil_rresp_i;
        m_axil_rready_o  = 1'b0;
        rd_tmr_clr       = 1'b0;
        rd_tmr_en        = 1'b0;
        rd_evt           = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                rd_tmr_clr       = 1'b1;
                m_axil_arvalid_o = run_q & s_axil_arvalid_i;
                s_axil_arready_o = run_q & m_axil_arready_i;
                if (m_axil_arvalid_o && m_axil_arready_i) begin
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                rd_tmr_en       = 1'b1;
                s_axil_rvalid_o = m_axil_rvalid_i;
                m_axil_rready_o = s_axil_rready_i;
                if (m_axil_rvalid_i && s_axil_rready_i) begin
                    rd_state_d = R_IDLE;
                    rd_evt     = (m_axil_rresp_i != OKAY);
                end else if (rd_expired && !m_axil_rvalid_i) begin
                    rd_state_d = R_ERR;
                    rd_evt     = 1'b1;
                end
            end
            R_ERR: begin
                s_axil_rvalid_o = 1'b1;
                s_axil_rresp_o  = timeout_resp(ERR_RESP_EN);
                if (s_axil_rready_i) begin
                    rd_state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                m_axil_rready_o = 1'b1;
                if (m_axil_rvalid_i) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Merge both channels into one pulse; silent when error reporting is disabled
    always_comb begin
        error_d   = ERR_RESP_EN & (wr_evt | rd_evt);
        err_src_d = ERR_RESP_EN ? {rd_evt, wr_evt} : 2'b00;
    end

    assign error_o   = error_q;
    assign err_src_o = err_src_q;

endmodule

// File: tb/tb_axil_timeout_guard.sv
// tb/tb_axil_timeout_guard.sv - self-checking bench for axil_timeout_guard
module tb_axil_timeout_guard;

    localparam int   ADDR_W  = 32;
    localparam int   DATA_W  = 32;
    localparam int   STRB_W  = DATA_W / 8;
    localparam int   TIMEOUT = 16;
    localparam logic ERR_EN  = 1'b1;

    logic aclk = 1'b0;
    logic rstn = 1'b0;
    always #5 aclk = ~aclk;

    logic [ADDR_W-1:0] s_awaddr = '0, s_araddr = '0, m_awaddr, m_araddr;
    logic [2:0]        s_awprot = '0, s_arprot = '0, m_awprot, m_arprot;
    logic              s_awvalid = 0, s_awready, s_wvalid = 0, s_wready;
    logic [DATA_W-1:0] s_wdata = '0, m_wdata, s_rdata, m_rdata = '0;
    logic [STRB_W-1:0] s_wstrb = '0, m_wstrb;
    logic [1:0]        s_bresp, m_bresp = 2'b00, s_rresp, m_rresp = 2'b00, err_src_o;
    logic              s_bvalid, s_bready = 0, s_arvalid = 0, s_arready, s_rvalid, s_rready = 0;
    logic              m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_bvalid = 0, m_bready;
    logic              m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, error_o;

    axil_timeout_guard #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_RESP_EN(ERR_EN)
    ) dut (
        .aclk(aclk), .rstn(rstn),
        .s_axil_awaddr_i(s_awaddr), .s_axil_awprot_i(s_awprot), .s_axil_awvalid_i(s_awvalid), .s_axil_awready_o(s_awready),
        .s_axil_wdata_i(s_wdata), .s_axil_wstrb_i(s_wstrb), .s_axil_wvalid_i(s_wvalid), .s_axil_wready_o(s_wready),
        .s_axil_bresp_o(s_bresp), .s_axil_bvalid_o(s_bvalid), .s_axil_bready_i(s_bready),
        .s_axil_araddr_i(s_araddr), .s_axil_arprot_i(s_arprot), .s_axil_arvalid_i(s_arvalid), .s_axil_arready_o(s_arready),
        .s_axil_rdata_o(s_rdata), .s_axil_rresp_o(s_rresp), .s_axil_rvalid_o(s_rvalid), .s_axil_rready_i(s_rready),
        .m_axil_awaddr_o(m_awaddr), .m_axil_awprot_o(m_awprot), .m_axil_awvalid_o(m_awvalid), .m_axil_awready_i(m_awready),
        .m_axil_wdata_o(m_wdata), .m_axil_wstrb_o(m_wstrb), .m_axil_wvalid_o(m_wvalid), .m_axil_wready_i(m_wready),
        .m_axil_bresp_i(m_bresp), .m_axil_bvalid_i(m_bvalid), .m_axil_bready_o(m_bready),
        .m_axil_araddr_o(m_araddr), .m_axil_arprot_o(m_arprot), .m_axil_arvalid_o(m_arvalid), .m_axil_arready_i(m_arready),
        .m_axil_rdata_i(m_rdata), .m_axil_rresp_i(m_rresp), .m_axil_rvalid_i(m_rvalid), .m_axil_rready_o(m_rready),
        .error_o(error_o), .err_src_o(err_src_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    logic [1:0] last_src = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: each channel is either accepting, or waiting on a request of some age
    bit w_busy = 0, w_won = 0, w_acked = 0, aw_seen = 0, w_seen = 0, m_live = 0;
    bit r_busy = 0, r_won = 0, r_acked = 0;
    int w_age = 0, r_age = 0;
    logic exp_err = 1'b0;
    logic [1:0] exp_src = 2'b00;

    always @(negedge aclk) begin : cmp
        logic w_to, r_to, e_awv, e_awr, e_wv, e_wr, e_bv, e_bq, e_arv, e_arr, e_rv, e_rq;
        logic aw_hs, w_hs, wev, rev;
        logic [1:0] e_bresp, e_rresp;
        logic [DATA_W-1:0] e_rdata;
        cyc++;
        if (error_o) begin
            err_pulses++;
            last_src = err_src_o;
        end
        if (!rstn) begin
            chk("rst_s_awready", s_awready, 0); chk("rst_s_wready", s_wready, 0);
            chk("rst_s_bvalid", s_bvalid, 0);   chk("rst_s_arready", s_arready, 0);
            chk("rst_s_rvalid", s_rvalid, 0);   chk("rst_m_awvalid", m_awvalid, 0);
            chk("rst_m_wvalid", m_wvalid, 0);   chk("rst_m_bready", m_bready, 0);
            chk("rst_m_arvalid", m_arvalid, 0); chk("rst_m_rready", m_rready, 0);
            chk("rst_error_o", error_o, 0);     chk("rst_err_src", err_src_o, 0);
            w_busy = 0; aw_seen = 0; w_seen = 0; r_busy = 0; m_live = 0;
            exp_err = 1'b0; exp_src = 2'b00;
        end else begin
            w_to  = w_busy && !w_won && (w_age >= TIMEOUT);
            r_to  = r_busy && !r_won && (r_age >= TIMEOUT);
            e_awv = m_live && !w_busy && !aw_seen && s_awvalid;
            e_awr = m_live && !w_busy && !aw_seen && m_awready;
            e_wv  = m_live && !w_busy && !w_seen && s_wvalid;
            e_wr  = m_live && !w_busy && !w_seen && m_wready;
            e_bv  = w_to ? !w_acked : (w_busy && m_bvalid);
            e_bq  = w_to ? w_acked : (w_busy && s_bready);
            e_bresp = w_to ? (ERR_EN ? 2'b10 : 2'b00) : m_bresp;
            e_arv = m_live && !r_busy && s_arvalid;
            e_arr = m_live && !r_busy && m_arready;
            e_rv  = r_to ? !r_acked : (r_busy && m_rvalid);
            e_rq  = r_to ? r_acked : (r_busy && s_rready);
            e_rresp = r_to ? (ERR_EN ? 2'b10 : 2'b00) : m_rresp;
            e_rdata = r_to ? '0 : m_rdata;

            chk("m_awvalid", m_awvalid, e_awv); chk("s_awready", s_awready, e_awr);
            chk("m_wvalid", m_wvalid, e_wv);    chk("s_wready", s_wready, e_wr);
            chk("s_bvalid", s_bvalid, e_bv);    chk("m_bready", m_bready, e_bq);
            chk("m_arvalid", m_arvalid, e_arv); chk("s_arready", s_arready, e_arr);
            chk("s_rvalid", s_rvalid, e_rv);    chk("m_rready", m_rready, e_rq);
            if (e_bv) chk("s_bresp", s_bresp, e_bresp);
            if (e_rv) begin
                chk("s_rresp", s_rresp, e_rresp);
                chk("s_rdata", s_rdata, e_rdata);
            end
            chk("m_awaddr", m_awaddr, s_awaddr); chk("m_awprot", m_awprot, s_awprot);
            chk("m_wdata", m_wdata, s_wdata);    chk("m_wstrb", m_wstrb, s_wstrb);
            chk("m_araddr", m_araddr, s_araddr); chk("m_arprot", m_arprot, s_arprot);
            chk("error_o", error_o, exp_err);    chk("err_src_o", err_src_o, exp_src);

            wev = 0;
            rev = 0;
            if (!w_busy) begin
                aw_hs = e_awv && e_awr;
                w_hs  = e_wv && e_wr;
                if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
                    w_busy = 1; w_age = 0; w_won = 0; w_acked = 0; aw_seen = 0; w_seen = 0;
                end else begin
                    aw_seen = aw_seen || aw_hs;
                    w_seen  = w_seen || w_hs;
                end
            end else begin
                if (w_to) begin
                    if (!w_acked) begin
                        w_acked = s_bready;
                    end else if (m_bvalid) begin
                        w_busy = 0;
                    end
                end else if (m_bvalid) begin
                    w_won = 1;
                    if (s_bready) begin
                        w_busy = 0;
                        wev = (m_bresp != 2'b00);
                    end
                end else if (w_age == TIMEOUT - 1) begin
                    wev = 1;
                end
                w_age++;
            end
            if (!r_busy) begin
                if (e_arv && e_arr) begin
                    r_busy = 1; r_age = 0; r_won = 0; r_acked = 0;
                end
            end else begin
                if (r_to) begin
                    if (!r_acked) begin
                        r_acked = s_rready;
                    end else if (m_rvalid) begin
                        r_busy = 0;
                    end
                end else if (m_rvalid) begin
                    r_won = 1;
                    if (s_rready) begin
                        r_busy = 0;
                        rev = (m_rresp != 2'b00);
                    end
                end else if (r_age == TIMEOUT - 1) begin
                    rev = 1;
                end
                r_age++;
            end
            exp_err = ERR_EN && (wev || rev);
            exp_src = ERR_EN ? {rev, wev} : 2'b00;
            m_live  = 1;
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic launch_write(input logic [31:0] addr, input logic [31:0] data);
        s_awaddr = addr; s_awvalid = 1; m_awready = 1;
        s_wdata = data; s_wstrb = 4'hf; s_wvalid = 1; m_wready = 1;
        step();
        s_awvalid = 0; m_awready = 0; s_wvalid = 0; m_wready = 0;
    endtask

    task automatic launch_read(input logic [31:0] addr);
        s_araddr = addr; s_arprot = 3'b010; s_arvalid = 1; m_arready = 1;
        step();
        s_arvalid = 0; m_arready = 0;
    endtask

    initial begin : stim
        int n;
        logic got;
        repeat (3) step();
        rstn = 1;
        @(negedge aclk);
        chk("post_rst_error", error_o, 0);
        chk("post_rst_bvalid", s_bvalid, 0);
        step();

        // Write with AW and W in separate cycles, slave B OKAY after 5 cycles
        err_pulses = 0;
        s_awaddr = 32'h0000_1000; s_awprot = 3'b001; s_awvalid = 1; m_awready = 1;
        step();
        s_awvalid = 0; m_awready = 0;
        s_wdata = 32'hCAFE_0001; s_wstrb = 4'h3; s_wvalid = 1; m_wready = 1;
        step();
        s_wvalid = 0; m_wready = 0;
        repeat (5) step();
        m_bvalid = 1; m_bresp = 2'b00; s_bready = 1;
        @(negedge aclk);
        chk("wr_ok_bvalid", s_bvalid, 1);
        chk("wr_ok_bresp", s_bresp, 2'b00);
        step();
        m_bvalid = 0; s_bready = 0;
        repeat (3) step();
        chk("wr_ok_no_err", err_pulses, 0);

        // Silent slave on read: guard answers SLVERR with zero data after 16 cycles
        err_pulses = 0;
        m_rdata = 32'hFFFF_FFFF;
        launch_read(32'h0000_2000);
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge aclk); n++;
            @(negedge aclk); got = s_rvalid;
        end
        chk("rd_to_latency", n, 16);
        chk("rd_to_rresp", s_rresp, 2'b10);
        chk("rd_to_rdata", s_rdata, 0);
        step();
        s_rready = 1;
        step();
        s_rready = 0;
        @(negedge aclk);
        chk("rd_drain_rready", m_rready, 1);
        step();
        m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
        step();
        m_rvalid = 0;
        step();
        chk("rd_to_pulses", err_pulses, 1);
        chk("rd_to_src", last_src, 2'b10);

        // Write timeout, late B swallowed in drain, next AW held off until drained
        err_pulses = 0;
        launch_write(32'h0000_3000, 32'h1111_2222);
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge aclk); n++;
            @(negedge aclk); got = s_bvalid;
        end
        chk("wr_to_latency", n, 16);
        chk("wr_to_bresp", s_bresp, 2'b10);
        step();
        s_bready = 1;
        step();
        s_bready = 0;
        s_awaddr = 32'h0000_4000; s_awvalid = 1; m_awready = 1;
        repeat (3) begin
            @(negedge aclk);
            chk("drain_aw_blocked", s_awready, 0);
            chk("drain_bready", m_bready, 1);
            step();
        end
        m_bvalid = 1; m_bresp = 2'b00;
        @(negedge aclk);
        chk("late_b_hidden", s_bvalid, 0);
        step();
        m_bvalid = 0;
        @(negedge aclk);
        chk("aw_after_drain", s_awready, 1);
        step();
        s_awvalid = 0; m_awready = 0;
        s_wvalid = 1; m_wready = 1;
        step();
        s_wvalid = 0; m_wready = 0;
        m_bvalid = 1; s_bready = 1;
        step();
        m_bvalid = 0; s_bready = 0;
        step();
        chk("wr_to_pulses", err_pulses, 1);
        chk("wr_to_src", last_src, 2'b01);

        // Slave B lands in the last allowed cycle: forwarded, no timeout
        err_pulses = 0;
        launch_write(32'h0000_5000, 32'h5555_AAAA);
        repeat (TIMEOUT - 1) @(posedge aclk);
        #1;
        m_bvalid = 1; m_bresp = 2'b00; s_bready = 1;
        @(negedge aclk);
        chk("edge_bvalid", s_bvalid, 1);
        chk("edge_bresp", s_bresp, 2'b00);
        step();
        m_bvalid = 0; s_bready = 0;
        repeat (4) step();
        chk("edge_no_err", err_pulses, 0);

        // Forwarded SLVERR from the slave raises a write-sourced pulse
        err_pulses = 0;
        launch_write(32'h0000_6000, 32'h0);
        repeat (2) step();
        m_bvalid = 1; m_bresp = 2'b10; s_bready = 1;
        @(negedge aclk);
        chk("slverr_fwd", s_bresp, 2'b10);
        step();
        m_bvalid = 0; s_bready = 0; m_bresp = 2'b00;
        repeat (2) step();
        chk("slverr_pulses", err_pulses, 1);
        chk("slverr_src", last_src, 2'b01);

        // Write and read time out together: a single merged pulse
        err_pulses = 0;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; m_awready = 1; m_wready = 1; m_arready = 1;
        step();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; m_awready = 0; m_wready = 0; m_arready = 0;
        repeat (20) step();
        chk("both_pulses", err_pulses, 1);
        chk("both_src", last_src, 2'b11);
        s_bready = 1; s_rready = 1;
        step();
        s_bready = 0; s_rready = 0;
        m_bvalid = 1; m_rvalid = 1;
        step();
        m_bvalid = 0; m_rvalid = 0;
        step();

        // Reset while a read is pending; the late R must not surface
        launch_read(32'h0000_7000);
        repeat (4) step();
        rstn = 0;
        step();
        m_rvalid = 1; m_rdata = 32'h0BAD_0BAD;
        step();
        rstn = 1;
        repeat (2) begin
            @(negedge aclk);
            chk("rst_mid_rvalid", s_rvalid, 0);
            chk("rst_mid_rready", m_rready, 0);
            chk("rst_mid_error", error_o, 0);
            step();
        end
        m_rvalid = 0;
        step();
        launch_read(32'h0000_8000);
        m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b00; s_rready = 1;
        @(negedge aclk);
        chk("recover_rdata", s_rdata, 32'h1234_5678);
        step();
        m_rvalid = 0; s_rready = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
